// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32I/M decode for the D stage, E/M/W control pipeline registers,
// and the load-use / taken-branch / mul-div hazard unit.
module ctrl_pipe #(
    parameter int ALUOP_W       = 5,
    parameter int EN_MEXT       = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode_d,
    input  logic [2:0]         funct3_d,
    input  logic [6:0]         funct7_d,
    input  logic [4:0]         rs1_d,
    input  logic [4:0]         rs2_d,
    input  logic [4:0]         rd_d,
    input  logic               branch_taken_e,
    output logic [2:0]         imm_sel_d,
    output logic               reg_write_e,
    output logic               reg_write_m,
    output logic               reg_write_w,
    output logic               mem_write_e,
    output logic               mem_write_m,
    output logic               mem_to_reg_e,
    output logic               mem_to_reg_m,
    output logic               mem_to_reg_w,
    output logic               branch_e,
    output logic               jump_e,
    output logic [1:0]         src_a_sel_e,
    output logic               src_b_sel_e,
    output logic [ALUOP_W-1:0] alu_op_e,
    output logic [2:0]         str_ctrl_e,
    output logic [2:0]         str_ctrl_m,
    output logic [4:0]         rd_e,
    output logic [4:0]         rd_m,
    output logic [4:0]         rd_w,
    output logic               illegal_e,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_d,
    output logic               md_busy
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_ALUR  = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [3:0] MD_LAST  = 4'(MULDIV_CYCLES - 1);

    typedef struct packed {
        logic               reg_write;
        logic               mem_write;
        logic               mem_to_reg;
        logic               branch;
        logic               jump;
        logic               illegal;
        logic               muldiv;
        logic [1:0]         src_a_sel;
        logic               src_b_sel;
        logic [ALUOP_W-1:0] alu_op;
        logic [2:0]         str_ctrl;
        logic [4:0]         rd;
    } ctl_t;

    ctl_t dec, ex, mm, wb;
    logic is_load, is_store, is_alui, is_alur, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic [3:0] cnt;
    logic load_use, hold_e;

    always_comb begin
        is_load  = opcode_d == OP_LOAD;
        is_store = opcode_d == OP_STORE;
        is_alui  = opcode_d == OP_ALUI;
        is_alur  = opcode_d == OP_ALUR;
        is_br    = opcode_d == OP_BR;
        is_jal   = opcode_d == OP_JAL;
        is_jalr  = opcode_d == OP_JALR;
        is_lui   = opcode_d == OP_LUI;
        is_auipc = opcode_d == OP_AUIPC;
        dec = '0;
        dec.reg_write  = is_load | is_alui | is_alur | is_jal | is_jalr | is_lui | is_auipc;
        dec.mem_write  = is_store;
        dec.mem_to_reg = is_load;
        dec.branch     = is_br;
        dec.jump       = is_jal | is_jalr;
        dec.illegal    = ~(is_load | is_store | is_alui | is_alur | is_br | is_jal | is_jalr | is_lui | is_auipc);
        dec.muldiv     = (EN_MEXT != 0) && is_alur && funct7_d == 7'b0000001;
        dec.src_a_sel  = (is_jal | is_jalr | is_auipc) ? 2'b00 : is_lui ? 2'b01 : 2'b11;
        dec.src_b_sel  = is_load | is_store | is_alui | is_jalr | is_lui | is_auipc;
        // funct7[5] selects sub/sra only where the encoding defines it; shifts-immediate use f3=101
        dec.alu_op     = ALUOP_W'({dec.muldiv,
                                   (is_alur | (is_alui && funct3_d == 3'b101)) & funct7_d[5],
                                   (is_alui | is_alur | is_br) ? funct3_d : 3'b000});
        dec.str_ctrl   = (is_load | is_store) ? funct3_d : 3'b000;
        dec.rd         = rd_d;
    end

    assign imm_sel_d = is_store ? 3'd1 : is_br ? 3'd2 : (is_lui | is_auipc) ? 3'd3 : is_jal ? 3'd4 : 3'd0;

    assign load_use = ex.mem_to_reg && ex.rd != 5'd0 && (ex.rd == rs1_d || ex.rd == rs2_d);
    assign md_busy  = ex.muldiv && cnt != MD_LAST;
    assign hold_e   = md_busy && !branch_taken_e;
    assign stall_f  = (load_use || md_busy) && !branch_taken_e;
    assign stall_d  = stall_f;
    assign flush_d  = branch_taken_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex  <= '0;
            mm  <= '0;
            wb  <= '0;
            cnt <= '0;
        end else begin
            wb <= mm;
            if (hold_e) begin
                mm  <= '0;
                cnt <= cnt + 4'd1;
            end else begin
                mm  <= ex;
                ex  <= (branch_taken_e || load_use) ? ctl_t'('0) : dec;
                cnt <= '0;
            end
        end
    end

    assign reg_write_e  = ex.reg_write;
    assign reg_write_m  = mm.reg_write;
    assign reg_write_w  = wb.reg_write;
    assign mem_write_e  = ex.mem_write;
    assign mem_write_m  = mm.mem_write;
    assign mem_to_reg_e = ex.mem_to_reg;
    assign mem_to_reg_m = mm.mem_to_reg;
    assign mem_to_reg_w = wb.mem_to_reg;
    assign branch_e     = ex.branch;
    assign jump_e       = ex.jump;
    assign src_a_sel_e  = ex.src_a_sel;
    assign src_b_sel_e  = ex.src_b_sel;
    assign alu_op_e     = ex.alu_op;
    assign str_ctrl_e   = ex.str_ctrl;
    assign str_ctrl_m   = mm.str_ctrl;
    assign rd_e         = ex.rd;
    assign rd_m         = mm.rd;
    assign rd_w         = wb.rd;
    assign illegal_e    = ex.illegal;
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Next-generation RV32I/M control unit. Decodes opcode/funct3/funct7 of the instruction held in the Decode stage.
- Carries the decoded control bundle through its own E, M and W pipeline registers.
- Generates hazard control: load-use stall, taken-branch flush, and a multi-cycle M-extension stall.
- Sits between the IF/ID register (owned by the datapath) and the E/M/W datapath muxes.

Parameters:
- ALUOP_W, 5, ALU op width: {muldiv, funct7[5]-derived bit, funct3}. Must be ≥5.
- EN_MEXT, 1, 1 = decode funct7==0000001 ALUreg ops as mul/div; 0 = treat them as plain ALUreg.
- MULDIV_CYCLES, 4, cycles a mul/div instruction occupies E. Range 1..16.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- opcode_d  in  7  opcode of the instruction in D.
- funct3_d  in  3  funct3 field.
- funct7_d  in  7  funct7 field.
- rs1_d, rs2_d, rd_d  in  5 each  register fields.
- branch_taken_e  in  1  branch/jump in E resolved taken.
- imm_sel_d  out  3  immediate format, combinational: I=0, S=1, B=2, U=3, J=4.
- reg_write_e/m/w  out  1 each  register-file write enable per stage.
- mem_write_e/m  out  1 each  store enable.
- mem_to_reg_e/m/w  out  1 each  load result selects writeback.
- branch_e, jump_e  out  1 each  conditional branch / JAL-JALR in E.
- src_a_sel_e  out  2  00 = PC (JAL/JALR/AUIPC), 01 = zero (LUI), 11 = rs1.
- src_b_sel_e  out  1  1 = immediate.
- alu_op_e  out  ALUOP_W  ALU operation.
- str_ctrl_e/m  out  3 each  funct3 of load/store, for width and sign.
- rd_e/m/w  out  5 each  destination register.
- illegal_e  out  1  unknown opcode reached E.
- stall_f, stall_d  out  1 each  hold PC / IF-ID.
- flush_d  out  1  clear IF-ID.
- md_busy  out  1  mul/div stall active.

Behaviour:
- Reset: every registered output is 0; md counter is 0; stall/flush outputs are 0 in the cycle after reset.
- Opcode map: Load 0000011, Store 0100011, ALUimm 0010011, ALUreg 0110011, Branch 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Decode fields:
  - reg_write = Load | ALUimm | ALUreg | JAL | JALR | LUI | AUIPC.
  - src_b_sel = Load | Store | ALUimm | JALR | LUI | AUIPC.
  - mem_write = Store; mem_to_reg = Load; branch = Branch; jump = JAL | JALR.
- alu_op:
  - bit3 = funct7[5] for ALUreg, or for ALUimm with funct3=101; otherwise 0.
  - bit4 (muldiv) = EN_MEXT & ALUreg & funct7==0000001.
  - Load/Store/LUI/AUIPC/JAL/JALR force funct3 field to 000 (add).
- Unknown opcode: all enables 0, illegal=1.
- Bubble: all enables, illegal, branch, jump, muldiv = 0; rd = 0.
- Load-use: if mem_to_reg_e & rd_e≠0 & (rd_e==rs1_d | rd_e==rs2_d):
  - stall_f = stall_d = 1;
  - bubble into E next cycle; E contents move on to M.
- Taken branch: branch_taken_e=1 → flush_d=1, and a bubble enters E next cycle. Flush beats stall for both D and E.
- Mul/div:
  - When muldiv_e=1, counter cnt increments each cycle.
  - md_busy = muldiv_e & (cnt ≠ MULDIV_CYCLES-1).
  - While md_busy: stall_f = stall_d = 1; E holds its contents; a bubble enters M; W advances normally.
  - When E advances, cnt clears to 0.
  - MULDIV_CYCLES=1 → never busy.
  - md_busy dominates load-use: no E bubble is inserted while busy.
- Otherwise E←D decode, M←E, W←M every cycle.
- Latency: decode in cycle t appears in E at t+1, M at t+2, W at t+3.
- rst mid-stall: all state clears and md_busy drops in the next cycle.

Test Plan:
- rst high for 2 cycles, then ADD x3 (ALUreg, f3=000, f7=0, rd=3) → reg_write_e=1 at t+1, reg_write_m/rd_m=3 at t+2, reg_write_w/rd_w=3 at t+3; alu_op_e=00000.
- LW x5 then ADD x6,x5,x1 → stall_f=stall_d=1 for exactly 1 cycle; next cycle reg_write_e=0 (bubble); ADD reaches E one cycle later. Same sequence with LW x0 → no stall.
- BEQ in E with branch_taken_e=1 → flush_d=1 that cycle; E bubble next cycle; following M stage shows the branch (reg_write_m=0), then the bubble.
- MUL (f7=0000001), MULDIV_CYCLES=4 → md_busy high 3 cycles; alu_op_e=10000 held throughout; bubbles in M during busy; MUL in M on the 4th cycle after entering E. With EN_MEXT=0 → no stall, alu_op_e=00000.
- SRAI (f3=101, f7=0100000) → alu_op_e=01101; ADDI with imm bit10 set (f7[5]=1, f3=000) → alu_op_e=00000. LUI → src_a_sel_e=01, src_b_sel_e=1, reg_write_e=1.
- Opcode 1111111 → illegal_e=1, all enables 0. rst asserted during md_busy → all outputs 0 next cycle.
